n_any_gate_serial: RTL and testbench

Multi-cycle, parametrised successor to the combinational N-input selectable gate. It accepts an N-bit operand and a 2-bit gate select over a valid/ready handshake. It reduces the operand W bits per cycle with an internal FSM and returns the 1-bit result over a second valid/ready handshake. It is intended for wide operands where a single-cycle N-input reduction tree would not meet timing.

---
 rtl/n_any_gate_pkg.sv | 24 ++
 rtl/n_any_gate_slice.sv | 23 ++
 rtl/n_any_gate_serial.sv | 124 ++++++++++++
 tb/tb_n_any_gate_serial.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/n_any_gate_pkg.sv
// Shared types and helpers for the serial N-input selectable gate.
package n_any_gate_pkg;

  // Gate operation encoding carried on gate_select.
  typedef enum logic [1:0] {
    GATE_AND  = 2'b00,
    GATE_XOR  = 2'b01,
    GATE_XNOR = 2'b10,
    GATE_OR   = 2'b11
  } gate_sel_t;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Accumulator start value: 1 for AND, 0 for XOR/XNOR/OR.
  function automatic logic identity(gate_sel_t sel);
    return (sel == GATE_AND);
  endfunction

endpackage

// File: rtl/n_any_gate_slice.sv
// Combinational reduction of one W-bit slice under the selected gate.
// XNOR reduces as XOR; the final inversion happens once at the output.
module n_any_gate_slice
  import n_any_gate_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] i_slice,
  input  gate_sel_t    i_sel,
  output logic         o_red
);

  // Select the slice reduction for the active gate.
  always_comb begin
    o_red = ^i_slice;
    unique case (i_sel)
      GATE_AND: o_red = &i_slice;
      GATE_OR:  o_red = |i_slice;
      default:  o_red = ^i_slice;
    endcase
  end

endmodule

// File: rtl/n_any_gate_serial.sv
// Multi-cycle N-input selectable gate: reduces the operand W bits per cycle
// between two valid/ready handshakes. All handshake outputs are registered.
module n_any_gate_serial
  import n_any_gate_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned W          = 2,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] gate_in,
  input  logic [1:0]   gate_select,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         gate_out
);

  localparam int unsigned NumSlices = N / W;
  localparam int unsigned CntW      = $clog2(NumSlices) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

  state_t          r_state;
  gate_sel_t       r_sel;
  logic [N-1:0]    r_opnd;
  logic [CntW-1:0] r_cnt;
  logic            r_acc;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_gate_out;

  logic            w_slice_red;
  logic            w_acc_next;
  logic            w_absorb;
  logic            w_last_slice;

  n_any_gate_slice #(
    .W (W)
  ) u_slice (
    .i_slice (r_opnd[W-1:0]),
    .i_sel   (r_sel),
    .o_red   (w_slice_red)
  );

  // Fold the current slice into the accumulator and detect absorbing values.
  always_comb begin
    w_acc_next = r_acc ^ w_slice_red;
    w_absorb   = 1'b0;
    unique case (r_sel)
      GATE_AND: begin
        w_acc_next = r_acc & w_slice_red;
        w_absorb   = ~w_acc_next;
      end
      GATE_OR: begin
        w_acc_next = r_acc | w_slice_red;
        w_absorb   = w_acc_next;
      end
      default: begin
        w_acc_next = r_acc ^ w_slice_red;
        w_absorb   = 1'b0;
      end
    endcase
  end

  // RUN ends on the final slice, or on an absorbing value when early exit is on.
  assign w_last_slice = (r_cnt == LastCnt) || (EARLY_EXIT && w_absorb);

  // Controller FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= GATE_AND;
      r_opnd      <= '0;
      r_cnt       <= '0;
      r_acc       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_gate_out  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opnd     <= gate_in;
            r_sel      <= gate_sel_t'(gate_select);
            r_acc      <= identity(gate_sel_t'(gate_select));
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_acc  <= w_acc_next;
          r_opnd <= r_opnd >> W;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last_slice) begin
            r_out_valid <= 1'b1;
            r_gate_out  <= (r_sel == GATE_XNOR) ? ~w_acc_next : w_acc_next;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // A new operand is only taken once back in IDLE.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign gate_out  = r_gate_out;

endmodule

// File: tb/tb_n_any_gate_serial.sv
// Directed bench for n_any_gate_serial (N=8, W=2), with and without early exit.
module tb_n_any_gate_serial;

  logic       clk;
  logic       rst;
  logic       in_valid0;
  logic       in_valid1;
  logic [7:0] gate_in;
  logic [1:0] gate_select;
  logic       out_ready;
  logic       in_ready0, out_valid0, gate_out0;
  logic       in_ready1, out_valid1, gate_out1;

  int checks;
  int failures;

  n_any_gate_serial #(
    .N          (8),
    .W          (2),
    .EARLY_EXIT (1'b0)
  ) u_dut0 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid0),
    .in_ready    (in_ready0),
    .gate_in     (gate_in),
    .gate_select (gate_select),
    .out_valid   (out_valid0),
    .out_ready   (out_ready),
    .gate_out    (gate_out0)
  );

  n_any_gate_serial #(
    .N          (8),
    .W          (2),
    .EARLY_EXIT (1'b1)
  ) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid1),
    .in_ready    (in_ready1),
    .gate_in     (gate_in),
    .gate_select (gate_select),
    .out_valid   (out_valid1),
    .out_ready   (out_ready),
    .gate_out    (gate_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand for one edge, then count edges until out_valid (bounded).
  task automatic run_op(input int which, input logic [7:0] val, input logic [1:0] sel,
                        output int lat, output logic res, output logic seen);
    gate_in     = val;
    gate_select = sel;
    if (which == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    gate_in   = ~val;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      seen = (which == 0) ? out_valid0 : out_valid1;
    end
    res = (which == 0) ? gate_out0 : gate_out1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready0, out_valid0, gate_out0} !== 3'b100) begin
      failures++;
      $display("FAIL reset_dut0 got=%b want=100", {in_ready0, out_valid0, gate_out0});
    end
    checks++;
    if ({in_ready1, out_valid1, gate_out1} !== 3'b100) begin
      failures++;
      $display("FAIL reset_dut1 got=%b want=100", {in_ready1, out_valid1, gate_out1});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Table-driven ops on one DUT: operand, select, expected latency and result.
  task automatic test_vectors(input int which, input string tag, input logic [7:0] vals[],
                              input logic [1:0] sels[], input int lats[], input logic ress[]);
    int   lat;
    logic res, seen;
    for (int i = 0; i < vals.size(); i++) begin
      run_op(which, vals[i], sels[i], lat, res, seen);
      checks++;
      if (!seen || lat != lats[i]) begin
        failures++;
        $display("FAIL %s_%0d_latency got=%0d want=%0d", tag, i, lat, lats[i]);
      end
      checks++;
      if (res !== ress[i]) begin
        failures++;
        $display("FAIL %s_%0d_result got=%b want=%b", tag, i, res, ress[i]);
      end
      consume();
    end
  endtask

  task automatic test_and();
    test_vectors(0, "and", '{8'hFF, 8'hFE}, '{2'b00, 2'b00}, '{4, 4}, '{1'b1, 1'b0});
  endtask

  task automatic test_xor_xnor();
    test_vectors(0, "xor", '{8'b1011_0001, 8'b1011_0001, 8'b0000_0001},
                 '{2'b01, 2'b10, 2'b01}, '{4, 4, 4}, '{1'b0, 1'b1, 1'b1});
  endtask

  task automatic test_or();
    test_vectors(0, "or", '{8'h00, 8'h80}, '{2'b11, 2'b11}, '{4, 4}, '{1'b0, 1'b1});
  endtask

  task automatic test_early_exit();
    test_vectors(1, "early", '{8'hFE, 8'h04, 8'h01, 8'hFF, 8'h00},
                 '{2'b00, 2'b11, 2'b01, 2'b00, 2'b11}, '{1, 2, 4, 4, 4},
                 '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
  endtask

  task automatic test_backpressure();
    int   lat;
    logic res, seen;
    run_op(0, 8'hFF, 2'b00, lat, res, seen);
    checks++;
    if (!seen || res !== 1'b1) begin
      failures++;
      $display("FAIL bp_first got=%b/%b want=1/1", seen, res);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        gate_in     = 8'h00;
        gate_select = 2'b00;
        in_valid0   = 1'b1;
      end
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      checks++;
      if ({out_valid0, gate_out0, in_ready0} !== 3'b110) begin
        failures++;
        $display("FAIL bp_hold_%0d got=%b want=110", c, {out_valid0, gate_out0, in_ready0});
      end
    end
    consume();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({out_valid0, in_ready0} !== 2'b01) begin
        failures++;
        $display("FAIL bp_idle_%0d got=%b want=01", c, {out_valid0, in_ready0});
      end
      @(posedge clk); #1;
    end
    run_op(0, 8'b0000_0011, 2'b01, lat, res, seen);
    checks++;
    if (!seen || lat != 4 || res !== 1'b0) begin
      failures++;
      $display("FAIL bp_next got=%b/%0d/%b want=1/4/0", seen, lat, res);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic res, seen;
    run_op(0, 8'hF0, 2'b11, lat, res, seen);
    // Offer the next operand together with out_ready in DONE.
    gate_in     = 8'hFF;
    gate_select = 2'b10;
    in_valid0   = 1'b1;
    out_ready   = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid0, in_ready0} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_idle got=%b want=01", {out_valid0, in_ready0});
    end
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    checks++;
    if (in_ready0 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept got=%b want=0", in_ready0);
    end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      seen = out_valid0;
    end
    checks++;
    if (!seen || lat != 4 || gate_out0 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_result got=%b/%0d/%b want=1/4/1", seen, lat, gate_out0);
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    logic res, seen;
    gate_in     = 8'hFE;
    gate_select = 2'b00;
    in_valid0   = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid0, in_ready0} !== 2'b01) begin
      failures++;
      $display("FAIL rst_async got=%b want=01", {out_valid0, in_ready0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_stale got=%b want=0", seen);
    end
    run_op(0, 8'hFF, 2'b00, lat, res, seen);
    checks++;
    if (!seen || lat != 4 || res !== 1'b1) begin
      failures++;
      $display("FAIL rst_recover got=%b/%0d/%b want=1/4/1", seen, lat, res);
    end
    consume();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    in_valid0   = 1'b0;
    in_valid1   = 1'b0;
    out_ready   = 1'b0;
    gate_in     = 8'h00;
    gate_select = 2'b00;
    test_reset();
    test_and();
    test_xor_xnor();
    test_or();
    test_early_exit();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
